// File: rtl/bus_xbar_pkg.sv
// Shared constants for the bus crossbar: slave/master indices and the address map.
package bus_xbar_pkg;

  localparam int NM_DEFAULT    = 3;
  localparam int NS_DEFAULT    = 6;
  localparam int OUTST_DEFAULT = 2;

  // Master indices
  localparam int MST_INSTR = 0;
  localparam int MST_DATA  = 1;
  localparam int MST_BOOT  = 2;

  // Slave indices
  localparam int SLV_ROM    = 0;
  localparam int SLV_RAM    = 1;
  localparam int SLV_IO     = 2;
  localparam int SLV_UART0  = 3;
  localparam int SLV_TIMER  = 4;
  localparam int SLV_TIMER1 = 5;

  // Address map, element [i] belongs to slave index i
  localparam logic [NS_DEFAULT-1:0][31:0] ADDR_BASE = {
    32'h8000_3000,  // TIMER1
    32'h8000_2000,  // TIMER
    32'h8000_1000,  // UART0
    32'h8000_0000,  // IO
    32'h0001_0000,  // RAM
    32'h0000_0000   // ROM
  };

  localparam logic [NS_DEFAULT-1:0][31:0] ADDR_MASK = {
    32'hFFFF_F000,
    32'hFFFF_F000,
    32'hFFFF_F000,
    32'hFFFF_F000,
    32'hFFFF_0000,
    32'hFFFF_0000
  };

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_xbar_rr_arb.sv
// Round-robin arbiter for one slave port; pointer moves past the winner only
// when the slave actually accepts the request.
module bus_xbar_rr_arb
  import bus_xbar_pkg::*;
#(
  parameter int NM = NM_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NM-1:0] req,
  input  logic          adv,
  output logic [NM-1:0] gnt
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   idx;
  logic          found;

  // Search requesters starting at the pointer, wrapping around once.
  always_comb begin
    gnt   = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NM)) idx = idx - (PW+1)'(NM);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        win              = idx[PW-1:0];
        found            = 1'b1;
      end
    end
  end

  // Pointer register: advance to winner+1 on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (win == PW'(NM-1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/bus_xbar.sv
// NM x NS crossbar for Ibex-style req/gnt/rvalid buses. In-order responses are
// guaranteed by blocking a master from switching slaves while it has traffic
// outstanding, so a per-slave FIFO of master IDs is enough to route responses.
module bus_xbar
  import bus_xbar_pkg::*;
#(
  parameter int NM    = NM_DEFAULT,
  parameter int NS    = NS_DEFAULT,
  parameter int OUTST = OUTST_DEFAULT,
  parameter logic [NS-1:0][31:0] SLV_BASE = ADDR_BASE,
  parameter logic [NS-1:0][31:0] SLV_MASK = ADDR_MASK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NM-1:0]        m_req,
  input  logic [NM-1:0]        m_we,
  input  logic [NM-1:0][3:0]   m_be,
  input  logic [NM-1:0][31:0]  m_addr,
  input  logic [NM-1:0][31:0]  m_wdata,
  output logic [NM-1:0]        m_gnt,
  output logic [NM-1:0]        m_rvalid,
  output logic [NM-1:0]        m_err,
  output logic [NM-1:0][31:0]  m_rdata,
  output logic [NS-1:0]        s_req,
  output logic [NS-1:0]        s_we,
  output logic [NS-1:0][3:0]   s_be,
  output logic [NS-1:0][31:0]  s_addr,
  output logic [NS-1:0][31:0]  s_wdata,
  input  logic [NS-1:0]        s_gnt,
  input  logic [NS-1:0]        s_rvalid,
  input  logic [NS-1:0]        s_err,
  input  logic [NS-1:0][31:0]  s_rdata
);

  localparam int MW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW  = $clog2(NS + 1);          // slave index incl. error slave
  localparam int CW  = $clog2(OUTST + 1);
  localparam int D   = NM * OUTST;              // routing FIFO depth
  localparam int FPW = (D > 1) ? $clog2(D) : 1;
  localparam int FCW = $clog2(D + 1);

  logic [SW-1:0]  dec     [NM];
  logic [CW-1:0]  cnt     [NM];
  logic [SW-1:0]  cur_slv [NM];
  logic [NM-1:0]  blocked;
  logic [NM-1:0]  req_ok;
  logic [NM-1:0]  err_gnt;
  logic [NM-1:0]  err_pend;

  logic [NM-1:0]  arb_req [NS];
  logic [NM-1:0]  arb_gnt [NS];
  logic [MW-1:0]  win_id  [NS];
  logic [NS-1:0]  push;
  logic [NS-1:0]  pop;

  logic [MW-1:0]  fifo_mem [NS][D];
  logic [FPW-1:0] wr_ptr   [NS];
  logic [FPW-1:0] rd_ptr   [NS];
  logic [FCW-1:0] fcnt     [NS];
  logic [MW-1:0]  head     [NS];

  // Address decode: lowest matching slave wins, no match selects the error slave.
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      dec[m] = SW'(NS);
      for (int s = NS - 1; s >= 0; s--) begin
        if (addr_match(m_addr[m], SLV_BASE[s], SLV_MASK[s])) dec[m] = SW'(s);
      end
    end
  end

  // Ordering guard: hold a master at its limit or when it tries to switch slaves.
  always_comb begin
    blocked = '0;
    req_ok  = '0;
    err_gnt = '0;
    for (int m = 0; m < NM; m++) begin
      blocked[m] = (cnt[m] == CW'(OUTST)) ||
                   ((cnt[m] != '0) && (cur_slv[m] != dec[m]));
      req_ok[m]  = m_req[m] && rst_n && !blocked[m];
      err_gnt[m] = req_ok[m] && (dec[m] == SW'(NS));
    end
  end

  // Per-slave arbiter request vectors.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      arb_req[s] = '0;
      for (int m = 0; m < NM; m++) begin
        arb_req[s][m] = req_ok[m] && (dec[m] == SW'(s));
      end
    end
  end

  genvar gs;
  for (gs = 0; gs < NS; gs++) begin : g_slv
    bus_xbar_rr_arb #(.NM(NM)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (arb_req[gs]),
      .adv   (push[gs]),
      .gnt   (arb_gnt[gs])
    );

    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push[gs] && !pop[gs] && (fcnt[gs] == FCW'(D))));
  end

  // Mux the arbitration winner onto each slave port; idle ports drive zero.
  always_comb begin
    s_req   = '0;
    s_we    = '0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int s = 0; s < NS; s++) begin
      win_id[s] = '0;
      s_req[s]  = |arb_req[s];
      for (int m = 0; m < NM; m++) begin
        if (arb_gnt[s][m]) begin
          s_we[s]    = m_we[m];
          s_be[s]    = m_be[m];
          s_addr[s]  = m_addr[m];
          s_wdata[s] = m_wdata[m];
          win_id[s]  = MW'(m);
        end
      end
    end
  end

  // Handshake / response strobes and FIFO head per slave.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      push[s] = s_req[s] && s_gnt[s];
      pop[s]  = s_rvalid[s] && (fcnt[s] != '0);
      head[s] = fifo_mem[s][rd_ptr[s]];
    end
  end

  // Master grant: error slave always accepts, real slaves through their arbiter.
  always_comb begin
    m_gnt = err_gnt;
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < NM; m++) begin
        if (arb_gnt[s][m] && s_gnt[s]) m_gnt[m] = 1'b1;
      end
    end
  end

  // Response routing; a response with an empty FIFO is silently dropped.
  always_comb begin
    m_rvalid = '0;
    m_err    = '0;
    m_rdata  = '0;
    for (int m = 0; m < NM; m++) begin
      if (err_pend[m]) begin
        m_rvalid[m] = 1'b1;
        m_err[m]    = 1'b1;
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (pop[s]) begin
        m_rvalid[head[s]] = 1'b1;
        m_err[head[s]]    = s_err[s];
        m_rdata[head[s]]  = s_rdata[s];
      end
    end
  end

  // Routing FIFOs holding the issuing master ID of each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        fcnt[s]   <= '0;
        for (int i = 0; i < D; i++) fifo_mem[s][i] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (push[s]) begin
          fifo_mem[s][wr_ptr[s]] <= win_id[s];
          wr_ptr[s] <= (wr_ptr[s] == FPW'(D-1)) ? '0 : wr_ptr[s] + FPW'(1);
        end
        if (pop[s]) begin
          rd_ptr[s] <= (rd_ptr[s] == FPW'(D-1)) ? '0 : rd_ptr[s] + FPW'(1);
        end
        fcnt[s] <= fcnt[s] + FCW'(push[s]) - FCW'(pop[s]);
      end
    end
  end

  // Outstanding counters, current-slave registers and the error-slave response stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend <= '0;
      for (int m = 0; m < NM; m++) begin
        cnt[m]     <= '0;
        cur_slv[m] <= '0;
      end
    end else begin
      err_pend <= err_gnt;
      for (int m = 0; m < NM; m++) begin
        cnt[m] <= cnt[m] + CW'(m_gnt[m]) - CW'(m_rvalid[m]);
        if (m_gnt[m]) cur_slv[m] <= dec[m];
      end
    end
  end

endmodule

// File: tb/tb_bus_xbar.sv
// Directed bench for bus_xbar: behavioural slaves with per-slave latency,
// expected responses queued per master and checked by a negedge monitor.
module tb_bus_xbar;
  import bus_xbar_pkg::*;

  localparam int NM = 3;
  localparam int NS = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NM-1:0]       m_req, m_we;
  logic [NM-1:0][3:0]  m_be;
  logic [NM-1:0][31:0] m_addr, m_wdata;
  logic [NM-1:0]       m_gnt, m_rvalid, m_err;
  logic [NM-1:0][31:0] m_rdata;
  logic [NS-1:0]       s_req, s_we;
  logic [NS-1:0][3:0]  s_be;
  logic [NS-1:0][31:0] s_addr, s_wdata;
  logic [NS-1:0]       s_gnt, s_rvalid, s_err;
  logic [NS-1:0][31:0] s_rdata;

  always #5 clk = ~clk;

  bus_xbar #(.NM(NM), .NS(NS), .OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
  );

  typedef struct { logic [31:0] d; logic e; } exp_t;
  typedef struct { int s; int due; logic [31:0] d; } pend_t;

  exp_t        exp_q [NM][$];
  pend_t       pend [$];
  int          lat [NS];
  logic [31:0] data_next [NS];
  int          rv_cyc [NM];
  int          rv_cnt [NM];
  int          cyc;
  int          n_vec;
  int          n_bad;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // Slave response driver: one response per slave per cycle, in acceptance order.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    s_rvalid = '0;
    s_rdata  = '0;
    s_err    = '0;
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].s == s) begin
          if (pend[i].due <= cyc) begin
            s_rvalid[s] = 1'b1;
            s_rdata[s]  = pend[i].d;
            pend.delete(i);
          end
          break;
        end
      end
    end
  end

  // Monitor: record slave handshakes and score every master response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int s = 0; s < NS; s++) begin
        if (s_req[s] && s_gnt[s]) begin
          pend.push_back('{s, cyc + lat[s], data_next[s]});
          data_next[s] = data_next[s] + 32'd1;
        end
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (m_rvalid[m]) begin
        rv_cyc[m] = cyc;
        rv_cnt[m]++;
        if (exp_q[m].size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rvalid_m%0d: got rdata %h, required no response", m, m_rdata[m]);
        end else begin
          e = exp_q[m].pop_front();
          check($sformatf("rdata_m%0d", m), m_rdata[m], e.d);
          check($sformatf("err_m%0d", m), {31'd0, m_err[m]}, {31'd0, e.e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic wait_gnt(input int m, output int gc);
    gc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_gnt[m]) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL gnt_timeout_m%0d: got no grant, required grant within 40 cycles", m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g, first_rv, n;
    int gc [3];
    cyc = 0; n_vec = 0; n_bad = 0;
    for (int m = 0; m < NM; m++) begin rv_cyc[m] = -1; rv_cnt[m] = 0; end
    for (int s = 0; s < NS; s++) begin lat[s] = 1; data_next[s] = '0; end
    idle_all();
    s_gnt = '1; s_rvalid = '0; s_err = '0; s_rdata = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_m_gnt",    {29'd0, m_gnt},    32'd0);
    check("rst_m_rvalid", {29'd0, m_rvalid}, 32'd0);
    check("rst_m_err",    {29'd0, m_err},    32'd0);
    check("rst_s_req",    {26'd0, s_req},    32'd0);
    check("rst_s_we",     {26'd0, s_we},     32'd0);
    tick();
    rst_n = 1'b1;

    // Single read: M1 -> UART0, response two cycles after grant
    tick();
    lat[SLV_UART0] = 2;
    data_next[SLV_UART0] = 32'hA5A5_0001;
    exp_q[1].push_back('{32'hA5A5_0001, 1'b0});
    m_req[1] = 1'b1; m_addr[1] = ADDR_BASE[SLV_UART0]; m_be[1] = 4'hF;
    @(negedge clk);
    check("single_gnt",    {29'd0, m_gnt}, 32'b010);
    check("single_s_req",  {26'd0, s_req}, 32'b001000);
    check("single_s_addr", s_addr[SLV_UART0], 32'h8000_1000);
    t = cyc;
    tick();
    idle_all();
    repeat (4) @(negedge clk);
    check("single_rv_cyc", rv_cyc[1], t + 2);
    check("single_rv_cnt_m0", rv_cnt[0], 0);
    check("single_rv_cnt_m2", rv_cnt[2], 0);

    // Contention: M0 and M1 on RAM every cycle, grants alternate
    tick();
    lat[SLV_RAM] = 1;
    data_next[SLV_RAM] = 32'h100;
    for (int k = 0; k < 3; k++) begin
      exp_q[0].push_back('{32'h100 + 32'(2*k), 1'b0});
      exp_q[1].push_back('{32'h101 + 32'(2*k), 1'b0});
    end
    m_req[0] = 1'b1; m_addr[0] = ADDR_BASE[SLV_RAM];
    m_req[1] = 1'b1; m_addr[1] = ADDR_BASE[SLV_RAM] + 32'h4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("contend_gnt_%0d", k), {29'd0, m_gnt},
            (k % 2 == 0) ? 32'b001 : 32'b010);
    end
    tick();
    idle_all();
    repeat (3) @(negedge clk);

    // Unmapped read from M1: error response in the next cycle
    tick();
    exp_q[1].push_back('{32'h0, 1'b1});
    m_req[1] = 1'b1; m_addr[1] = 32'hFFFF_FFF0;
    @(negedge clk);
    check("unmap_gnt",   {29'd0, m_gnt}, 32'b010);
    check("unmap_s_req", {26'd0, s_req}, 32'd0);
    t = cyc;
    tick();
    idle_all();
    @(negedge clk);
    check("unmap_s_req_next", {26'd0, s_req}, 32'd0);
    @(negedge clk);
    check("unmap_rv_cyc", rv_cyc[1], t + 1);

    // Unmapped write from M2: discarded, still answered with an error
    tick();
    exp_q[2].push_back('{32'h0, 1'b1});
    m_req[2] = 1'b1; m_we[2] = 1'b1; m_be[2] = 4'hF;
    m_addr[2] = 32'hFFFF_FFF0; m_wdata[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("unmap_wr_gnt",  {29'd0, m_gnt}, 32'b100);
    check("unmap_wr_s_we", {26'd0, s_we},  32'd0);
    t = cyc;
    tick();
    idle_all();
    repeat (2) @(negedge clk);
    check("unmap_wr_rv_cyc", rv_cyc[2], t + 1);

    // Write to TIMER from M2: field muxing
    tick();
    data_next[SLV_TIMER] = 32'h700;
    exp_q[2].push_back('{32'h700, 1'b0});
    m_req[2] = 1'b1; m_we[2] = 1'b1; m_be[2] = 4'h3;
    m_addr[2] = ADDR_BASE[SLV_TIMER] + 32'h8; m_wdata[2] = 32'h1234_5678;
    @(negedge clk);
    check("wr_gnt",     {29'd0, m_gnt}, 32'b100);
    check("wr_s_we",    {26'd0, s_we},  32'b010000);
    check("wr_s_be",    {28'd0, s_be[SLV_TIMER]}, 32'h3);
    check("wr_s_addr",  s_addr[SLV_TIMER],  32'h8000_2008);
    check("wr_s_wdata", s_wdata[SLV_TIMER], 32'h1234_5678);
    tick();
    idle_all();
    repeat (3) @(negedge clk);

    // Order guard: M1 RAM (5-cycle response) then IO, IO held until after response
    tick();
    lat[SLV_RAM] = 5;
    data_next[SLV_RAM] = 32'h200;
    data_next[SLV_IO]  = 32'h300;
    exp_q[1].push_back('{32'h200, 1'b0});
    exp_q[1].push_back('{32'h300, 1'b0});
    m_req[1] = 1'b1; m_addr[1] = ADDR_BASE[SLV_RAM];
    @(negedge clk);
    check("guard_ram_gnt", {29'd0, m_gnt}, 32'b010);
    t = cyc;
    tick();
    m_addr[1] = ADDR_BASE[SLV_IO];
    wait_gnt(1, g);
    check("guard_io_gnt_cyc", g, t + 6);
    tick();
    idle_all();
    repeat (3) @(negedge clk);

    // OUTST limit: M0 streams ROM reads with 4-cycle responses
    tick();
    lat[SLV_ROM] = 4;
    data_next[SLV_ROM] = 32'h400;
    for (int k = 0; k < 3; k++) exp_q[0].push_back('{32'h400 + 32'(k), 1'b0});
    m_req[0] = 1'b1; m_addr[0] = ADDR_BASE[SLV_ROM];
    n = 0; first_rv = -1;
    gc[0] = -1; gc[1] = -1; gc[2] = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_rvalid[0] && first_rv < 0) first_rv = cyc;
      if (m_gnt[0]) begin
        gc[n] = cyc;
        n++;
      end
      if (n == 3) break;
    end
    tick();
    idle_all();
    check("outst_grants",    n, 3);
    check("outst_b2b",       gc[1], gc[0] + 1);
    check("outst_first_rv",  first_rv, gc[0] + 4);
    check("outst_third_gnt", gc[2], gc[0] + 5);
    repeat (8) @(negedge clk);

    // Reset in the middle of an outstanding RAM read
    tick();
    lat[SLV_RAM] = 6;
    data_next[SLV_RAM] = 32'h500;
    m_req[0] = 1'b1; m_addr[0] = ADDR_BASE[SLV_RAM];
    @(negedge clk);
    check("rstmid_gnt", {29'd0, m_gnt}, 32'b001);
    tick();
    idle_all();
    tick();
    rst_n = 1'b0;
    m_req[2] = 1'b1; m_addr[2] = ADDR_BASE[SLV_IO];
    #1;
    check("rstmid_m_gnt",    {29'd0, m_gnt},    32'd0);
    check("rstmid_m_rvalid", {29'd0, m_rvalid}, 32'd0);
    check("rstmid_m_err",    {29'd0, m_err},    32'd0);
    check("rstmid_m_rdata",  m_rdata[0] | m_rdata[1] | m_rdata[2], 32'd0);
    check("rstmid_s_req",    {26'd0, s_req},    32'd0);
    check("rstmid_s_we",     {26'd0, s_we},     32'd0);
    check("rstmid_s_addr",   s_addr[SLV_IO] | s_addr[SLV_RAM], 32'd0);
    tick();
    idle_all();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_rvalid[SLV_RAM]) begin
        n = 1;
        check("late_rsp_dropped", {29'd0, m_rvalid}, 32'd0);
        break;
      end
    end
    check("late_rsp_seen", n, 1);

    // Pointers restart at M0 after reset
    tick();
    lat[SLV_RAM] = 1;
    data_next[SLV_RAM] = 32'h600;
    exp_q[0].push_back('{32'h600, 1'b0});
    exp_q[1].push_back('{32'h601, 1'b0});
    m_req[0] = 1'b1; m_addr[0] = ADDR_BASE[SLV_RAM];
    m_req[1] = 1'b1; m_addr[1] = ADDR_BASE[SLV_RAM];
    @(negedge clk);
    check("post_rst_gnt0", {29'd0, m_gnt}, 32'b001);
    @(negedge clk);
    check("post_rst_gnt1", {29'd0, m_gnt}, 32'b010);
    tick();
    idle_all();
    repeat (6) @(negedge clk);

    for (int m = 0; m < NM; m++) check($sformatf("drain_m%0d", m), exp_q[m].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_xbar.md
# bus_xbar

Parametrised successor to the single-master `bus_mux`. It is a crossbar between `NM` Ibex-protocol masters (core instruction port, core data port, BootLoader) and `NS` slaves (instruction ROM, data RAM, IO, UART0, Timer, Timer1, …). Each slave has its own round-robin arbiter, and the crossbar tracks outstanding transactions so that every master receives its responses in order. Unmapped addresses are answered with an error response, never a hang.

## Interface
- `NM`, default 3: number of masters; index 0 has the highest priority after reset.
- `NS`, default 6: number of slaves.
- `OUTST`, default 2: maximum outstanding transactions per master.
- `SLV_BASE`, default `ADDR_BASE` from package: `NS`×32 base addresses.
- `SLV_MASK`, default `ADDR_MASK` from package: `NS`×32 masks. A slave matches when `(addr & mask) == base`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `m_req`, `m_we`  in  `NM`  master request / write enable
- `m_be`  in  `NM`×4  byte enables
- `m_addr`, `m_wdata`  in  `NM`×32  address / write data
- `m_gnt`, `m_rvalid`, `m_err`  out  `NM`  grant / response valid / error
- `m_rdata`  out  `NM`×32  read data
- `s_req`, `s_we`  out  `NS`  slave request / write enable
- `s_be`  out  `NS`×4
- `s_addr`, `s_wdata`  out  `NS`×32
- `s_gnt`, `s_rvalid`, `s_err`  in  `NS`
- `s_rdata`  in  `NS`×32

## Operation
- **Decode:** each master address is decoded against `SLV_BASE`/`SLV_MASK`; the lowest matching index wins. No match selects the internal error slave, index `NS`.
- **Blocking rules:** master m is blocked (its request is not forwarded and `m_gnt[m]=0`) when either holds:
  - it has `OUTST` transactions outstanding;
  - it has transactions outstanding to a slave other than the one now decoded.

  These rules guarantee in-order responses without reorder buffers.
- **Arbitration:**
  - Per slave, round-robin among unblocked masters decoding to it.
  - The pointer advances to winner+1 only on a completed handshake (`s_req & s_gnt`).
  - The winner's `we`/`be`/`addr`/`wdata` are muxed onto the slave; losers see `m_gnt=0`.
- **Routing FIFO:**
  - Per slave, a FIFO of depth `NM*OUTST` holds the master ID; it is pushed on each handshake.
  - On `s_rvalid`, the head ID selects the master: `m_rvalid`, `m_rdata` and `m_err` are driven from that slave, then the FIFO pops.
- **Outstanding counter:** each master has a counter plus a current-slave register. It increments on grant, decrements on `m_rvalid`; both in one cycle leaves it unchanged.
- **Error slave:**
  - Always grants.
  - Returns `m_rvalid=1`, `m_err=1`, `m_rdata=0` exactly one cycle after the grant.
  - Writes are discarded.
- **Protection cases:**
  - `s_rvalid` arriving with an empty routing FIFO is dropped.
  - Routing-FIFO overflow is impossible by construction; guard it with an assertion.

## Timing
- **Reset values:** all `m_gnt`, `m_rvalid`, `m_err`, `s_req`, `s_we` = 0. `m_rdata`, `s_be`, `s_addr`, `s_wdata` = 0. Arbiter pointers = 0; counters and FIFOs empty.
- **Request path:** combinational, with zero added latency (`m_req` → `s_req` → `s_gnt` → `m_gnt` in the same cycle).
- **Response path:** combinational; `m_rvalid` is asserted in the same cycle as `s_rvalid`.
- **Back-to-back traffic:** a master can be granted every cycle while it stays on the same slave and under `OUTST`.
- **Slave switch:** the first request to a new slave is granted no earlier than the cycle after the last outstanding response.
- **Grant and response together:** in one cycle, a grant and a response for the same master are both honoured; the counter is unchanged.
- **Reset mid-transaction:** asserting reset clears all state immediately. Responses arriving after release are dropped.

## Structure
- **Package `bus_xbar_pkg`:**
  - `ADDR_BASE`/`ADDR_MASK` arrays, which replace the per-peripheral `addrBASE_*` defines.
  - Slave index constants: `SLV_ROM`, `SLV_RAM`, `SLV_IO`, `SLV_UART0`, `SLV_TIMER`, `SLV_TIMER1`.
  - Master index constants: `MST_INSTR`, `MST_DATA`, `MST_BOOT`.
- **Sub-module `bus_xbar_rr_arb`:** `NM`-wide round-robin arbiter with `req`, `adv`, one-hot `gnt` and a pointer register. It is instantiated once per slave.
- **Routing FIFOs and error slave:** inline in `bus_xbar`.

## Test plan
- **Single read:** M1 reads `SLV_UART0` base; the slave grants, then returns rvalid with `rdata=0xA5A5_0001` two cycles later → M1 sees `m_gnt` in the same cycle and `m_rvalid` with `0xA5A5_0001` in the slave's rvalid cycle. No other master sees rvalid.
- **Contention:** M0 and M1 both hold requests to `SLV_RAM` every cycle for 6 cycles, with the slave always granting → grants alternate M0, M1, M0, M1, M0, M1, and each response is routed back to its issuer.
- **Unmapped address:** M1 reads `0xFFFF_FFF0` → `m_gnt=1` in cycle t; `m_rvalid=1`, `m_err=1`, `m_rdata=0` in t+1. No `s_req` toggles.
- **Order guard:** M1 issues to RAM (response delayed 5 cycles), then requests IO → the IO request is held (`m_gnt=0`) until the RAM response. The IO grant then follows, at the earliest in the next cycle.
- **OUTST limit:** M0 issues 3 reads to ROM, whose responses are delayed 4 cycles → the third `m_gnt` is withheld until the first `m_rvalid`.
- **Reset mid-traffic:** pull `rst_n` low during an outstanding RAM read → all outputs are 0 immediately. A late `s_rvalid` after release is not forwarded, and the pointers restart at M0.
